// File: rtl/clique_enum_seq_if.sv
// Clique stream interface: one N-bit vertex mask per valid/ready handshake.
//   clique_valid : producer -> consumer, mask is a complete clique
//   clique_ready : consumer -> producer, accepts the current mask
//   clique_mask  : producer -> consumer, bit v set = vertex v in clique
interface clique_enum_seq_if #(
    parameter int unsigned N = 8
) ();
    logic         clique_valid;
    logic         clique_ready;
    logic [N-1:0] clique_mask;

    modport master (
        output clique_valid,
        output clique_mask,
        input  clique_ready
    );

    modport slave (
        input  clique_valid,
        input  clique_mask,
        output clique_ready
    );
endinterface

// File: rtl/clique_enum_seq.sv
// Sequential k-clique enumerator. Depth-first search over an explicit stack
// of candidate sets, one step per cycle; every k-clique is streamed as a
// vertex mask in lexicographic order of its sorted vertex list.
//   clk, rst     : clock, asynchronous active-high reset
//   start, k     : one-cycle request and clique size (sampled in IDLE)
//   adj_matrix   : N*N adjacency, bit i*N+j = edge i->j (sampled with start)
//   abort        : cancels a running search
//   busy, done   : search in progress / one-cycle end-of-search pulse
//   err          : k invalid for the last start
//   cq           : clique stream (valid/ready/mask)
//   num_cliques  : cliques accepted so far (saturating), overflow on saturation
module clique_enum_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned KMAX  = 5,
    parameter int unsigned K_W   = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [K_W-1:0]         k,
    input  logic [N*N-1:0]         adj_matrix,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    clique_enum_seq_if.master      cq,
    output logic [CNT_W-1:0]       num_cliques,
    output logic                   overflow
);

    localparam int unsigned VW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NA   = 1 << VW;
    localparam int unsigned DW   = $clog2(KMAX + 1);
    localparam int unsigned DA   = 1 << DW;
    localparam int unsigned KLIM = (KMAX < N) ? KMAX : N;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    nxt;

    logic [N-1:0]  adj    [NA];
    logic [N-1:0]  cand   [DA];
    logic [VW-1:0] chosen [DA];
    logic [DW-1:0] d;
    logic [DW-1:0] k_r;
    logic          valid_q;
    logic [N-1:0]  mask_q;

    logic          k_ok;
    logic          handshake;
    logic [N-1:0]  adj_sym [NA];
    logic [N-1:0]  cur_cand;
    logic [VW-1:0] v_sel;
    logic [N-1:0]  rem_cand;
    logic [N-1:0]  next_cand;
    logic [N-1:0]  emit_mask;

    assign cq.clique_valid = valid_q;
    assign cq.clique_mask  = mask_q;

    assign k_ok      = (k != '0) && (32'(k) <= KLIM);
    assign handshake = valid_q && cq.clique_ready;

    // Lowest set bit picks the next branch, which yields lexicographic order.
    function automatic logic [VW-1:0] lowest(input logic [N-1:0] x);
        logic [VW-1:0] r;
        r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (x[i]) r = VW'(i);
        end
        return r;
    endfunction

    // Only mutual edges count; the diagonal is dropped.
    always_comb begin
        for (int i = 0; i < int'(NA); i++) adj_sym[i] = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (i != j) adj_sym[i][j] = adj_matrix[i*N + j] & adj_matrix[j*N + i];
            end
        end
    end

    // One search step and the mask of the current full stack.
    always_comb begin
        cur_cand  = cand[d];
        v_sel     = lowest(cur_cand);
        rem_cand  = cur_cand & ~(N'(1) << v_sel);
        next_cand = rem_cand & adj[v_sel];
        emit_mask = '0;
        for (int unsigned i = 0; i < KMAX; i++) begin
            if (i < 32'(k_r)) emit_mask = emit_mask | (N'(1) << chosen[DW'(i)]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (start) nxt = k_ok ? S_SEARCH : S_DONE;
            end
            S_SEARCH: begin
                if (abort)                              nxt = S_DONE;
                else if (d == k_r)                      nxt = S_EMIT;
                else if (cur_cand == '0 && d == '0)     nxt = S_DONE;
            end
            S_EMIT: begin
                if (abort)          nxt = S_DONE;
                else if (handshake) nxt = S_SEARCH;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Datapath, stack and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            valid_q     <= 1'b0;
            mask_q      <= '0;
            num_cliques <= '0;
            overflow    <= 1'b0;
            d           <= '0;
            k_r         <= '0;
            for (int i = 0; i < int'(DA); i++) begin
                cand[i]   <= '0;
                chosen[i] <= '0;
            end
            for (int i = 0; i < int'(NA); i++) adj[i] <= '0;
        end else begin
            busy <= (nxt == S_SEARCH) || (nxt == S_EMIT);
            done <= (nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err         <= !k_ok;
                        num_cliques <= '0;
                        overflow    <= 1'b0;
                        if (k_ok) begin
                            for (int i = 0; i < int'(NA); i++) adj[i] <= adj_sym[i];
                            k_r     <= DW'(k);
                            cand[0] <= '1;
                            d       <= '0;
                        end
                    end
                end
                S_SEARCH: begin
                    if (!abort) begin
                        if (d == k_r) begin
                            mask_q  <= emit_mask;
                            valid_q <= 1'b1;
                        end else if (cur_cand != '0) begin
                            cand[d]           <= rem_cand;
                            chosen[d]         <= v_sel;
                            cand[d + DW'(1)]  <= next_cand;
                            d                 <= d + DW'(1);
                        end else if (d != '0) begin
                            d <= d - DW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                    end else if (handshake) begin
                        valid_q <= 1'b0;
                        d       <= d - DW'(1);
                        if (num_cliques == '1) overflow    <= 1'b1;
                        else                   num_cliques <= num_cliques + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clique_enum_seq.sv
// Bench for clique_enum_seq: an N=5 instance and an N=8 instance (6-bit
// counter), checked every cycle against a brute-force subset enumerator.
module tb_clique_enum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start5, start8, abort, ready;
    logic [4:0]  k_in;
    logic [63:0] adj_in;

    logic        busy5, done5, err5, ovf5;
    logic [15:0] num5;
    logic        busy8, done8, err8, ovf8;
    logic [5:0]  num8;

    always #5 clk = ~clk;

    clique_enum_seq_if #(.N(5)) if5 ();
    clique_enum_seq_if #(.N(8)) if8 ();
    assign if5.clique_ready = ready;
    assign if8.clique_ready = ready;

    clique_enum_seq #(.N(5), .KMAX(5), .K_W(5), .CNT_W(16)) u5 (
        .clk(clk), .rst(rst), .start(start5), .abort(abort), .k(k_in),
        .adj_matrix(adj_in[24:0]), .busy(busy5), .done(done5), .err(err5),
        .cq(if5.master), .num_cliques(num5), .overflow(ovf5)
    );

    clique_enum_seq #(.N(8), .KMAX(5), .K_W(5), .CNT_W(6)) u8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort), .k(k_in),
        .adj_matrix(adj_in), .busy(busy8), .done(done8), .err(err8),
        .cq(if8.master), .num_cliques(num8), .overflow(ovf8)
    );

    // Active-instance view.
    logic        sel;
    logic        m_valid, m_busy, m_done, m_err, m_ovf;
    logic [7:0]  m_mask;
    logic [15:0] m_num;
    assign m_valid = sel ? if8.clique_valid : if5.clique_valid;
    assign m_mask  = sel ? if8.clique_mask  : {3'b000, if5.clique_mask};
    assign m_busy  = sel ? busy8 : busy5;
    assign m_done  = sel ? done8 : done5;
    assign m_err   = sel ? err8  : err5;
    assign m_ovf   = sel ? ovf8  : ovf5;
    assign m_num   = sel ? {10'd0, num8} : num5;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [7:0] exp_q [$];
    logic       exp_err;
    int         idx, hs, maxcnt;
    bit         aborted, done_seen, chk_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // All k-subsets whose every pair is mutually connected, in lex order.
    task automatic build_model(input logic [63:0] a, input int n, input int kk);
        longint key_q [$];
        logic [7:0] tm;
        longint tk;
        exp_q.delete();
        exp_err = !(kk >= 1 && kk <= 5 && kk <= n);
        if (!exp_err) begin
            for (int m = 0; m < (1 << n); m++) begin
                int pc;
                bit ok;
                longint key;
                pc = 0; ok = 1'b1; key = 0;
                for (int i = 0; i < n; i++) begin
                    if (m[i]) begin
                        pc++;
                        key = key * 16 + longint'(i);
                        for (int j = i + 1; j < n; j++)
                            if (m[j] && !(a[i*n + j] && a[j*n + i])) ok = 1'b0;
                    end
                end
                if (pc == kk && ok) begin
                    exp_q.push_back(8'(m));
                    key_q.push_back(key);
                end
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                for (int j = 0; j < exp_q.size() - 1 - i; j++) begin
                    if (key_q[j] > key_q[j+1]) begin
                        tk = key_q[j]; key_q[j] = key_q[j+1]; key_q[j+1] = tk;
                        tm = exp_q[j]; exp_q[j] = exp_q[j+1]; exp_q[j+1] = tm;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_valid) begin
                if (idx < exp_q.size()) chk("clique_mask", 64'(m_mask), 64'(exp_q[idx]));
                else begin
                    checks++; errors++;
                    $display("FAIL extra_clique: got mask 0x%0h, expected none at %0t", m_mask, $time);
                end
            end
            chk("num_cliques", 64'(m_num), 64'((hs > maxcnt) ? maxcnt : hs));
            chk("overflow", 64'(m_ovf), 64'(hs > maxcnt));
            chk("busy", 64'(m_busy), 64'(!m_done));
            if (m_valid && ready) begin
                hs++;
                idx++;
            end
            if (m_done) begin
                done_seen = 1'b1;
                chk("err", 64'(m_err), 64'(exp_err));
                if (!aborted) chk("clique_total", 64'(idx), 64'(exp_q.size()));
            end
        end
    end

    // Called at posedge+1; leaves the bench at posedge+1 after the start edge.
    task automatic kick(input bit s, input logic [63:0] a, input int kk);
        sel = s;
        maxcnt = s ? 63 : 65535;
        build_model(a, s ? 8 : 5, kk);
        idx = 0; hs = 0; aborted = 1'b0; done_seen = 1'b0;
        adj_in = a;
        k_in = 5'(kk);
        if (s) start8 = 1'b1; else start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0; start8 = 1'b0;
        adj_in = ~a;
        chk_en = 1'b1;
        chk("busy_after_start", 64'(m_busy), 64'(!exp_err));
        chk("done_after_start", 64'(m_done), 64'(exp_err));
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done_seen && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", bound);
        end
        chk_en = 1'b0;
    endtask

    task automatic wait_valid_hs(input int min_hs, input int bound);
        int n;
        n = 0;
        while (!(m_valid && hs >= min_hs) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(m_valid && hs >= min_hs)) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got no clique_valid, expected one after %0d handshakes", min_hs);
        end
    endtask

    logic [63:0] g;

    initial begin
        rst = 1'b1; start5 = 1'b0; start8 = 1'b0; abort = 1'b0; ready = 1'b1;
        k_in = '0; adj_in = '0; sel = 1'b0; chk_en = 1'b0;
        idx = 0; hs = 0; maxcnt = 0; aborted = 1'b0; done_seen = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state8", 64'({busy8, done8, err8, if8.clique_valid, ovf8}), 64'd0);
        chk("rst_mask8", 64'(if8.clique_mask), 64'd0);
        chk("rst_num8", 64'(num8), 64'd0);
        chk("rst_state5", 64'({busy5, done5, err5, if5.clique_valid, ovf5}), 64'd0);
        chk("rst_num5", 64'(num5), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two triangles on five vertices.
        g = '0;
        g[0*5+1] = 1; g[1*5+0] = 1; g[0*5+2] = 1; g[2*5+0] = 1;
        g[1*5+2] = 1; g[2*5+1] = 1; g[1*5+3] = 1; g[3*5+1] = 1;
        g[2*5+3] = 1; g[3*5+2] = 1; g[3*5+4] = 1; g[4*5+3] = 1;
        kick(1'b0, g, 3);
        chk("model_tri_size", 64'(exp_q.size()), 64'd2);
        chk("model_tri_first", 64'(exp_q[0]), 64'h07);
        chk("model_tri_second", 64'(exp_q[1]), 64'h0E);
        wait_done(200);
        chk("tri_num", 64'(num5), 64'd2);
        chk("tri_err_ovf", 64'({err5, ovf5}), 64'd0);

        // Same graph with backpressure on the first clique.
        ready = 1'b0;
        kick(1'b0, g, 3);
        wait_valid_hs(0, 50);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_mask", 64'(m_mask), 64'h07);
            chk("bp_num", 64'(m_num), 64'd0);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_num_after", 64'(m_num), 64'd1);
        wait_done(200);
        chk("bp_num_final", 64'(num5), 64'd2);

        // k=1 on an empty 8-vertex graph.
        kick(1'b1, 64'd0, 1);
        chk("model_k1_size", 64'(exp_q.size()), 64'd8);
        chk("model_k1_last", 64'(exp_q[7]), 64'h80);
        wait_done(200);
        chk("k1_num", 64'(num8), 64'd8);

        // Invalid k values.
        kick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_done(5);
        chk("k0_err_num", 64'({err8, num8}), 64'h40);
        kick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6);
        wait_done(5);
        chk("k6_err_num", 64'({err8, num8}), 64'h40);

        // One-directional edge and self-loops are not edges.
        kick(1'b1, 64'h2, 2);
        wait_done(200);
        chk("asym_num", 64'(num8), 64'd0);
        g = '0;
        for (int i = 0; i < 8; i++) g[i*8+i] = 1'b1;
        kick(1'b1, g, 2);
        wait_done(200);
        chk("selfloop_num", 64'({err8, num8}), 64'd0);

        // K8, k=4: 70 cliques into a 6-bit counter.
        kick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        chk("model_k8_size", 64'(exp_q.size()), 64'd70);
        chk("model_k8_first", 64'(exp_q[0]), 64'h0F);
        chk("model_k8_last", 64'(exp_q[69]), 64'hF0);
        wait_done(5000);
        chk("k8_num", 64'(num8), 64'd63);
        chk("k8_ovf", 64'(ovf8), 64'd1);

        // Asynchronous reset while a clique is offered.
        kick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        wait_valid_hs(3, 500);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 64'({busy8, done8, err8, if8.clique_valid, ovf8}), 64'd0);
        chk("arst_mask", 64'(if8.clique_mask), 64'd0);
        chk("arst_num", 64'(num8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("arst_no_done", 64'(done8), 64'd0);
        end

        // Abort mid-stream, with a start attempt during busy.
        kick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        wait_valid_hs(2, 500);
        k_in = 5'd0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_valid_hs(5, 500);
        ready = 1'b0;
        abort = 1'b1;
        aborted = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done", 64'(m_done), 64'd1);
        chk("abort_valid", 64'(m_valid), 64'd0);
        chk("abort_num", 64'(m_num), 64'd5);
        wait_done(5);
        ready = 1'b1;
        chk("abort_err", 64'(err8), 64'd0);
        @(posedge clk); #1;
        chk("abort_idle", 64'({busy8, done8}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
